// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared definitions for the instruction fetch stage: datapath
//                width, reset address, canonical NOP, instruction size, the
//                {instr, pc} record carried through the stage, and small
//                address helpers.
//  Contents    : XLEN, RESET_PC_DEFAULT, INSTR_NOP, ILEN_BYTES,
//                fetch_word_t, word_align(), next_word()
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_stage_pkg;

    localparam int                XLEN             = 32;
    localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0]   INSTR_NOP        = 32'h0000_0013;  // addi x0, x0, 0
    localparam int                ILEN_BYTES       = 4;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_word_t;

    // Instructions are always 4-byte aligned; the low two address bits are
    // discarded rather than trapped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // Sequential successor; wraps naturally modulo 2^XLEN.
    function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] addr);
        return addr + XLEN'(ILEN_BYTES);
    endfunction

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_if
//  Description : Bundles every non-clock signal of the fetch stage: the
//                redirect request from execute, the instruction-memory read
//                port, and the valid/ready output channel towards decode.
//  Modports    : master - the fetch stage itself
//                slave  - the surrounding pipeline / memory (environment)
//  Signals     : redirect_valid, redirect_target  (execute -> fetch)
//                imem_en, imem_addr               (fetch -> memory)
//                imem_rdata                       (memory -> fetch, 1 cycle later)
//                out_valid, out_instr, out_pc,
//                out_pc_plus4                     (fetch -> decode)
//                out_ready                        (decode -> fetch)
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;

    logic            imem_en;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_pc_plus4;

    modport master (
        input  redirect_valid,
        input  redirect_target,
        output imem_en,
        output imem_addr,
        input  imem_rdata,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4
    );

    modport slave (
        output redirect_valid,
        output redirect_target,
        input  imem_en,
        input  imem_addr,
        output imem_rdata,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4
    );

endinterface : fetch_stage_if
`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_buffer
//  Description : Single-entry holding register for one fetched {instr, pc}.
//                Used to park a memory response that decode could not accept
//                in the cycle it arrived, since the memory does not hold its
//                read data.
//  Ports       : clk, rst_n     clock, asynchronous active-low reset
//                i_capture      load i_word into the entry
//                i_release      the held entry has been consumed
//                i_flush        discard the entry (wins over capture/release)
//                i_word         word to capture
//                o_valid        entry is occupied
//                o_word         held word
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_skid_buffer
    import fetch_stage_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        i_capture,
    input  wire logic        i_release,
    input  wire logic        i_flush,
    input  wire fetch_word_t i_word,
    output logic             o_valid,
    output fetch_word_t      o_word
);

    logic        valid_q;
    logic        valid_d;
    fetch_word_t word_q;
    fetch_word_t word_d;

    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;

        if (i_flush) begin
            valid_d = 1'b0;
        end else if (i_capture) begin
            valid_d = 1'b1;
            word_d  = i_word;
        end else if (i_release) begin
            valid_d = 1'b0;
        end
    end

    // The data half is a don't-care while empty; it is reset to a NOP only
    // so that waveforms show something meaningful.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            word_q.instr <= INSTR_NOP;
            word_q.pc    <= RESET_PC_DEFAULT;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
        end
    end

    assign o_valid = valid_q;
    assign o_word  = word_q;

endmodule : fetch_skid_buffer
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage. Owns the program counter, issues
//                reads to a synchronous instruction memory (1-cycle latency)
//                and presents {instr, pc, pc+4} to decode via valid/ready.
//                A redirect from execute kills the in-flight read and any
//                held word and refetches from the target, costing one bubble.
//  Parameters  : XLEN      address / instruction width
//                RESET_PC  address of the first fetch after reset
//  Ports       : clk       clock, rising edge
//                rst_n     asynchronous active-low reset
//                bus       fetch_stage_if.master (redirect, imem, decode)
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter int              XLEN     = fetch_stage_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = fetch_stage_pkg::RESET_PC_DEFAULT
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    fetch_stage_if.master  bus
);
    import fetch_stage_pkg::*;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0] pc_q;          // next sequential fetch address
    logic [XLEN-1:0] pc_d;
    logic            req_valid_q;   // a read was issued last cycle
    logic            req_valid_d;
    logic [XLEN-1:0] req_pc_q;      // address of that read
    logic [XLEN-1:0] req_pc_d;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic            w_issue;
    logic [XLEN-1:0] w_fetch_addr;
    logic            w_capture;
    logic            w_release;
    logic            w_skid_valid;
    fetch_word_t     w_skid_word;
    fetch_word_t     w_resp_word;
    fetch_word_t     w_out_word;

    // A new read is safe whenever the slot it will land in is guaranteed
    // free next cycle: either decode drains the current word now, a
    // redirect throws the current word away, or nothing is held at all.
    // Otherwise the one word already fetched must be parked and no more
    // are requested, so at most one word is ever outstanding.
    always_comb begin
        w_issue      = bus.redirect_valid
                     | bus.out_ready
                     | (!w_skid_valid & !req_valid_q);
        w_fetch_addr = bus.redirect_valid ? word_align(bus.redirect_target) : pc_q;
    end

    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        // Without an issue the in-flight word is either consumed or parked
        // in the skid this cycle, so the request slot always empties.
        req_valid_d = w_issue;

        if (w_issue) begin
            pc_d     = next_word(w_fetch_addr);
            req_pc_d = w_fetch_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= word_align(RESET_PC);
            req_valid_q <= 1'b0;
            req_pc_q    <= word_align(RESET_PC);
        end else begin
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            req_pc_q    <= req_pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Skid buffer: parks the memory response when decode stalls
    // ------------------------------------------------------------------
    always_comb begin
        w_resp_word.instr = bus.imem_rdata;
        w_resp_word.pc    = req_pc_q;
        w_capture         = req_valid_q & !bus.out_ready & !bus.redirect_valid;
        w_release         = w_skid_valid & bus.out_ready;
    end

    fetch_skid_buffer u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_capture (w_capture),
        .i_release (w_release),
        .i_flush   (bus.redirect_valid),
        .i_word    (w_resp_word),
        .o_valid   (w_skid_valid),
        .o_word    (w_skid_word)
    );

    // ------------------------------------------------------------------
    // Output mux: the held word is always older than the memory response
    // ------------------------------------------------------------------
    always_comb begin
        w_out_word = w_skid_valid ? w_skid_word : w_resp_word;
    end

    // imem_en is qualified with rst_n so no read is requested while the
    // stage is held in reset (the issue term alone would be true then).
    assign bus.imem_en      = rst_n & w_issue;
    assign bus.imem_addr    = w_fetch_addr;
    assign bus.out_valid    = !bus.redirect_valid & (w_skid_valid | req_valid_q);
    assign bus.out_instr    = w_out_word.instr;
    assign bus.out_pc       = w_out_word.pc;
    assign bus.out_pc_plus4 = next_word(w_out_word.pc);

endmodule : fetch_stage
`default_nettype wire
